spi_master_xfer_ctrl: RTL and testbench

//  Sequences one SPI full-duplex transfer on the single-lane bus (sclk, cs, mosi0, miso0) from a pclk domain.
//  - Divides pclk into sclk and handles the CPOL/CPHA modes.
//  - Honours the cs-to-first-edge (c2t) and last-edge-to-cs (t2c) delays.
//  - Shifts tx_data out on mosi0 and captures miso0 into rx_data.
//  - Active transactor that drives the bus checked by the slave assertion bench.

---
 rtl/spi_master_xfer_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_spi_master_xfer_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_xfer_ctrl.sv
// spi_master_xfer_ctrl: single-lane SPI master that runs one full-duplex word.
// Divides pclk into sclk, frames cs with c2t/t2c delays, handles CPOL/CPHA.
module spi_master_xfer_ctrl #(
    parameter int NO_OF_SLAVES = 1,
    parameter int DATA_WIDTH   = 8,
    parameter int DIV_WIDTH    = 8,
    parameter int DLY_WIDTH    = 8
) (
    input  logic                              pclk,
    input  logic                              areset,
    input  logic                              cpol,
    input  logic                              cpha,
    input  logic                              msb_first,
    input  logic [DIV_WIDTH-1:0]              baud_div,
    input  logic [DLY_WIDTH-1:0]              c2t_delay,
    input  logic [DLY_WIDTH-1:0]              t2c_delay,
    input  logic                              tx_valid,
    output logic                              tx_ready,
    input  logic [DATA_WIDTH-1:0]             tx_data,
    input  logic [$clog2(NO_OF_SLAVES):0]     tx_slave_sel,
    output logic                              rx_valid,
    output logic [DATA_WIDTH-1:0]             rx_data,
    output logic                              busy,
    output logic                              sclk,
    output logic [NO_OF_SLAVES-1:0]           cs,
    output logic                              mosi0,
    input  logic                              miso0
);

    localparam int SEL_W = $clog2(NO_OF_SLAVES) + 1;
    localparam int CNT_W = (DIV_WIDTH > DLY_WIDTH) ? DIV_WIDTH : DLY_WIDTH;
    localparam int EDGES = 2 * DATA_WIDTH;
    localparam int EDG_W = $clog2(EDGES + 1);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [EDG_W-1:0] EDG_ONE = EDG_W'(1);
    localparam logic [EDG_W-1:0] EDG_END = EDG_W'(EDGES);
    localparam logic [EDG_W-1:0] EDG_LST = EDG_W'(EDGES - 1);

    typedef enum logic [2:0] {
        IDLE,
        C2T,
        XFER,
        T2C,
        DONE
    } state_t;

    state_t                  state_q;
    logic                    cpol_q;
    logic                    cpha_q;
    logic                    msb_q;
    logic [DIV_WIDTH-1:0]    h_q;
    logic [DLY_WIDTH-1:0]    c2t_q;
    logic [DLY_WIDTH-1:0]    t2c_q;
    logic [DATA_WIDTH-1:0]   tx_sh_q;
    logic [DATA_WIDTH-1:0]   rx_sh_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [EDG_W-1:0]        edge_q;
    logic                    sclk_q;
    logic [NO_OF_SLAVES-1:0] cs_q;
    logic                    mosi_q;
    logic                    rx_valid_q;
    logic [DATA_WIDTH-1:0]   rx_data_q;
    logic                    busy_q;

    logic [DIV_WIDTH-1:0]    h_d;
    logic [NO_OF_SLAVES-1:0] cs_d;
    logic                    first_bit_d;
    logic [DATA_WIDTH-1:0]   tx_after_first_d;
    logic                    tx_bit_d;
    logic [DATA_WIDTH-1:0]   tx_shift_d;
    logic [DATA_WIDTH-1:0]   rx_next_d;
    logic                    half_done;
    logic                    c2t_done;
    logic                    t2c_done;
    logic                    sample_edge;
    logic                    last_edge;

    assign h_d = (baud_div == '0) ? DIV_WIDTH'(1) : baud_div;

    // An out-of-range select leaves every chip select deasserted.
    always_comb begin
        cs_d = '1;
        for (int i = 0; i < NO_OF_SLAVES; i++) begin
            if (tx_slave_sel == SEL_W'(i)) begin
                cs_d[i] = 1'b0;
            end
        end
    end

    assign first_bit_d      = msb_first ? tx_data[DATA_WIDTH-1] : tx_data[0];
    assign tx_after_first_d = msb_first ? (tx_data << 1) : (tx_data >> 1);
    assign tx_bit_d         = msb_q ? tx_sh_q[DATA_WIDTH-1] : tx_sh_q[0];
    assign tx_shift_d       = msb_q ? (tx_sh_q << 1) : (tx_sh_q >> 1);
    assign rx_next_d        = msb_q ? {rx_sh_q[DATA_WIDTH-2:0], miso0}
                                    : {miso0, rx_sh_q[DATA_WIDTH-1:1]};

    assign half_done   = cnt_q == (CNT_W'(h_q) - CNT_ONE);
    assign c2t_done    = cnt_q == (CNT_W'(c2t_q) - CNT_ONE);
    assign t2c_done    = cnt_q == (CNT_W'(t2c_q) - CNT_ONE);
    // edge_q counts completed edges, so the upcoming edge is odd when it is even.
    assign sample_edge = ~edge_q[0] ^ cpha_q;
    assign last_edge   = edge_q == EDG_LST;

    always_ff @(posedge pclk) begin
        if (areset) begin
            state_q    <= IDLE;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            msb_q      <= 1'b0;
            h_q        <= '0;
            c2t_q      <= '0;
            t2c_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            cnt_q      <= '0;
            edge_q     <= '0;
            sclk_q     <= 1'b0;
            cs_q       <= '1;
            mosi_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    sclk_q <= cpol;
                    cs_q   <= '1;
                    busy_q <= 1'b0;
                    if (tx_valid) begin
                        cpol_q  <= cpol;
                        cpha_q  <= cpha;
                        msb_q   <= msb_first;
                        h_q     <= h_d;
                        c2t_q   <= c2t_delay;
                        t2c_q   <= t2c_delay;
                        rx_sh_q <= '0;
                        cnt_q   <= '0;
                        edge_q  <= '0;
                        busy_q  <= 1'b1;
                        cs_q    <= cs_d;
                        if (!cpha) begin
                            mosi_q  <= first_bit_d;
                            tx_sh_q <= tx_after_first_d;
                        end else begin
                            tx_sh_q <= tx_data;
                        end
                        state_q <= (c2t_delay == '0) ? XFER : C2T;
                    end
                end
                C2T: begin
                    if (c2t_done) begin
                        cnt_q   <= '0;
                        state_q <= XFER;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                XFER: begin
                    if (edge_q == EDG_END) begin
                        cnt_q  <= '0;
                        sclk_q <= cpol_q;
                        if (t2c_q == '0) begin
                            state_q    <= DONE;
                            cs_q       <= '1;
                            rx_valid_q <= 1'b1;
                            rx_data_q  <= rx_sh_q;
                        end else begin
                            state_q <= T2C;
                        end
                    end else if (half_done) begin
                        cnt_q  <= '0;
                        sclk_q <= ~sclk_q;
                        edge_q <= edge_q + EDG_ONE;
                        if (sample_edge) begin
                            rx_sh_q <= rx_next_d;
                        end else if (!last_edge) begin
                            mosi_q  <= tx_bit_d;
                            tx_sh_q <= tx_shift_d;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                T2C: begin
                    sclk_q <= cpol_q;
                    if (t2c_done) begin
                        state_q    <= DONE;
                        cs_q       <= '1;
                        rx_valid_q <= 1'b1;
                        rx_data_q  <= rx_sh_q;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx_ready = (state_q == IDLE);
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign busy     = busy_q;
    assign sclk     = sclk_q;
    assign cs       = cs_q;
    assign mosi0    = mosi_q;

endmodule

// File: tb/tb_spi_master_xfer_ctrl.sv
// Bench for spi_master_xfer_ctrl: vector table of single transfers plus
// back-to-back and mid-transfer reset sequences, with an edge-counting slave.
module tb_spi_master_xfer_ctrl;

    logic       pclk = 1'b0;
    logic       areset = 1'b1;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
    logic       msb_first = 1'b1;
    logic [7:0] baud_div = 8'd1;
    logic [7:0] c2t_delay = 8'd0;
    logic [7:0] t2c_delay = 8'd0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] tx_data = 8'h00;
    logic [2:0] tx_slave_sel = 3'd0;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       busy;
    logic       sclk;
    logic [3:0] cs;
    logic       mosi0;
    logic       miso0;

    logic       loopback = 1'b1;
    logic       miso_s = 1'b0;

    assign miso0 = loopback ? mosi0 : miso_s;

    always #5 pclk = ~pclk;

    spi_master_xfer_ctrl #(
        .NO_OF_SLAVES(4),
        .DATA_WIDTH(8),
        .DIV_WIDTH(8),
        .DLY_WIDTH(8)
    ) dut (
        .pclk(pclk),
        .areset(areset),
        .cpol(cpol),
        .cpha(cpha),
        .msb_first(msb_first),
        .baud_div(baud_div),
        .c2t_delay(c2t_delay),
        .t2c_delay(t2c_delay),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_data(tx_data),
        .tx_slave_sel(tx_slave_sel),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .busy(busy),
        .sclk(sclk),
        .cs(cs),
        .mosi0(mosi0),
        .miso0(miso0)
    );

    // Bus monitor and slave model, evaluated 2 time units after each posedge.
    int         mcyc = 0;
    int         edge_cnt = 0;
    int         first_e = -1;
    int         last_e = -1;
    int         cs_fall = -1;
    int         cs_rise = -1;
    int         mosi_bad = 0;
    int         sbit = 0;
    logic [7:0] slave_rx = 8'h00;
    logic       prev_sclk = 1'b0;
    logic       prev_mosi = 1'b0;
    logic       prev_busy = 1'b0;
    logic [3:0] prev_cs = 4'hF;
    logic       mon_clr = 1'b0;
    logic       s_cpha = 1'b0;
    logic       s_msb = 1'b1;
    logic [7:0] s_word = 8'h00;
    logic       is_edge;
    logic       samp;

    always begin
        @(posedge pclk);
        #2;
        mcyc++;
        if (mon_clr) begin
            edge_cnt = 0;
            first_e  = -1;
            last_e   = -1;
            cs_fall  = -1;
            cs_rise  = -1;
            mosi_bad = 0;
            sbit     = 0;
            slave_rx = 8'h00;
        end else begin
            if (prev_cs == 4'hF && cs != 4'hF) begin
                cs_fall = mcyc;
                if (!s_cpha) begin
                    miso_s = s_msb ? s_word[7-sbit] : s_word[sbit];
                    sbit++;
                end
            end
            if (prev_cs != 4'hF && cs == 4'hF) cs_rise = mcyc;
            is_edge = busy && (sclk != prev_sclk);
            samp    = 1'b0;
            if (is_edge) begin
                edge_cnt++;
                if (first_e < 0) first_e = mcyc;
                last_e = mcyc;
                samp = ((edge_cnt % 2) == 1) ^ s_cpha;
                if (samp) begin
                    slave_rx = s_msb ? {slave_rx[6:0], mosi0}
                                     : {mosi0, slave_rx[7:1]};
                end else if (sbit < 8) begin
                    miso_s = s_msb ? s_word[7-sbit] : s_word[sbit];
                    sbit++;
                end
            end
            if (busy && prev_busy && mosi0 != prev_mosi && !(is_edge && !samp))
                mosi_bad++;
        end
        prev_sclk = sclk;
        prev_mosi = mosi0;
        prev_busy = busy;
        prev_cs   = cs;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge pclk);
    endtask

    typedef struct {
        logic       cpol;
        logic       cpha;
        logic       msb;
        logic [7:0] baud;
        logic [7:0] c2t;
        logic [7:0] t2c;
        logic [7:0] data;
        logic [2:0] sel;
        logic       loopback;
        logic [7:0] sword;
        logic [7:0] exp_rx;
        int         first;
        int         last;
        int         done;
        logic [3:0] exp_cs;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int  t0;
        bit  got;
        int  pulses;
        int  gap;
        bit  dropped;
        int  rxv_seen;
        logic [7:0] rx1;
        logic [7:0] rx2;

        vecs[0] = '{1'b0, 1'b0, 1'b1, 8'd2, 8'd1, 8'd1, 8'hA5, 3'd0, 1'b1,
                    8'h00, 8'hA5, 4, 34, 36, 4'hE};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 8'd1, 8'd2, 8'd3, 8'h3C, 3'd0, 1'b0,
                    8'hC3, 8'hC3, 4, 19, 23, 4'hE};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 8'h5A, 3'd0, 1'b1,
                    8'h00, 8'h5A, 2, 17, 18, 4'hE};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 8'd3, 8'd0, 8'd2, 8'h96, 3'd2, 1'b1,
                    8'h00, 8'h96, 4, 49, 52, 4'hB};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 8'd1, 8'd3, 8'd0, 8'h0F, 3'd5, 1'b1,
                    8'h00, 8'h0F, 5, 20, 21, 4'hF};

        areset = 1'b1;
        repeat (3) step();
        chk("rst_sclk", int'(sclk), 0);
        chk("rst_cs", int'(cs), 'hF);
        chk("rst_mosi", int'(mosi0), 0);
        chk("rst_rx_valid", int'(rx_valid), 0);
        chk("rst_rx_data", int'(rx_data), 0);
        chk("rst_busy", int'(busy), 0);
        areset = 1'b0;
        step();
        chk("rst_tx_ready", int'(tx_ready), 1);

        for (int v = 0; v < 5; v++) begin
            cpol         = vecs[v].cpol;
            cpha         = vecs[v].cpha;
            msb_first    = vecs[v].msb;
            baud_div     = vecs[v].baud;
            c2t_delay    = vecs[v].c2t;
            t2c_delay    = vecs[v].t2c;
            tx_data      = vecs[v].data;
            tx_slave_sel = vecs[v].sel;
            loopback     = vecs[v].loopback;
            s_cpha       = vecs[v].cpha;
            s_msb        = vecs[v].msb;
            s_word       = vecs[v].sword;
            mon_clr = 1'b1;
            step();
            mon_clr = 1'b0;
            step();
            chk($sformatf("v%0d_sclk_idle", v), int'(sclk), int'(vecs[v].cpol));
            chk($sformatf("v%0d_ready", v), int'(tx_ready), 1);
            tx_valid = 1'b1;
            t0 = mcyc;
            step();
            tx_valid     = 1'b0;
            tx_data      = ~vecs[v].data;
            baud_div     = 8'd5;
            c2t_delay    = 8'd7;
            t2c_delay    = 8'd7;
            cpha         = ~vecs[v].cpha;
            msb_first    = ~vecs[v].msb;
            cpol         = ~vecs[v].cpol;
            tx_slave_sel = 3'd1;
            chk($sformatf("v%0d_cs_active", v), int'(cs), int'(vecs[v].exp_cs));
            got = 1'b0;
            for (int i = 0; i < 400 && !got; i++) begin
                step();
                if (rx_valid) got = 1'b1;
            end
            chk($sformatf("v%0d_rx_valid_seen", v), int'(got), 1);
            chk($sformatf("v%0d_rx_data", v), int'(rx_data), int'(vecs[v].exp_rx));
            chk($sformatf("v%0d_done_cyc", v), mcyc - t0, vecs[v].done);
            chk($sformatf("v%0d_busy_done", v), int'(busy), 1);
            chk($sformatf("v%0d_cs_done", v), int'(cs), 'hF);
            chk($sformatf("v%0d_first_edge", v), first_e - t0, vecs[v].first);
            chk($sformatf("v%0d_last_edge", v), last_e - t0, vecs[v].last);
            chk($sformatf("v%0d_edges", v), edge_cnt, 16);
            chk($sformatf("v%0d_slave_rx", v), int'(slave_rx), int'(vecs[v].data));
            chk($sformatf("v%0d_mosi_timing", v), mosi_bad, 0);
            chk($sformatf("v%0d_cs_fall", v),
                (cs_fall < 0) ? -1 : cs_fall - t0,
                (vecs[v].exp_cs == 4'hF) ? -1 : 1);
            chk($sformatf("v%0d_cs_rise", v),
                (cs_rise < 0) ? -1 : cs_rise - t0,
                (vecs[v].exp_cs == 4'hF) ? -1 : vecs[v].done);
            step();
            chk($sformatf("v%0d_rx_valid_pulse", v), int'(rx_valid), 0);
            chk($sformatf("v%0d_busy_after", v), int'(busy), 0);
            chk($sformatf("v%0d_ready_after", v), int'(tx_ready), 1);
        end

        // Back-to-back words with tx_valid held high.
        cpol = 1'b0; cpha = 1'b0; msb_first = 1'b1;
        baud_div = 8'd1; c2t_delay = 8'd0; t2c_delay = 8'd0;
        tx_slave_sel = 3'd0; loopback = 1'b1;
        s_cpha = 1'b0; s_msb = 1'b1;
        repeat (2) step();
        tx_valid = 1'b1;
        tx_data  = 8'h11;
        pulses = 0; gap = 0; dropped = 1'b0; rx1 = 8'h00; rx2 = 8'h00;
        for (int i = 0; i < 120 && pulses < 2; i++) begin
            step();
            if (cs != 4'hF && pulses == 0) tx_data = 8'h22;
            if (rx_valid) begin
                pulses++;
                if (pulses == 1) rx1 = rx_data;
                else rx2 = rx_data;
            end
            if (pulses == 1 && cs == 4'hF) gap++;
            if (pulses == 1 && cs != 4'hF && !dropped) begin
                tx_valid = 1'b0;
                dropped  = 1'b1;
            end
        end
        tx_valid = 1'b0;
        chk("b2b_pulses", pulses, 2);
        chk("b2b_rx1", int'(rx1), 'h11);
        chk("b2b_rx2", int'(rx2), 'h22);
        chk("b2b_cs_gap", gap, 2);
        rxv_seen = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (rx_valid) rxv_seen++;
        end
        chk("b2b_no_third", rxv_seen, 0);
        chk("b2b_ready", int'(tx_ready), 1);

        // Reset asserted at edge 5 of a transfer.
        baud_div = 8'd2; c2t_delay = 8'd1; t2c_delay = 8'd1;
        tx_data = 8'hA5;
        mon_clr = 1'b1;
        step();
        mon_clr = 1'b0;
        step();
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (edge_cnt >= 5) got = 1'b1;
            else step();
        end
        chk("rst_mid_edge5_reached", int'(got), 1);
        chk("rst_mid_sclk_before", int'(sclk), 1);
        areset = 1'b1;
        step();
        chk("rst_mid_cs", int'(cs), 'hF);
        chk("rst_mid_sclk", int'(sclk), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_rx_valid", int'(rx_valid), 0);
        chk("rst_mid_mosi", int'(mosi0), 0);
        chk("rst_mid_rx_data", int'(rx_data), 0);
        step();
        areset = 1'b0;
        rxv_seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (rx_valid) rxv_seen++;
        end
        chk("rst_mid_no_rx_valid", rxv_seen, 0);
        chk("rst_mid_ready", int'(tx_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
